// File: rtl/a2d_rr_sched.sv
`default_nettype none
// ============================================================================
// Module : a2d_rr_sched
// Round-robin sequencer sharing one SPI A2D among lft/rght/steer/batt slots.
// Rev    : 1.0  initial release
// ============================================================================
module a2d_rr_sched #(
   parameter logic [15:0] TMO_CYCLES = 16'd2048,
   parameter logic [2:0]  CH_LFT     = 3'd0,
   parameter logic [2:0]  CH_RGHT    = 3'd4,
   parameter logic [2:0]  CH_STEER   = 3'd5,
   parameter logic [2:0]  CH_BATT    = 3'd6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   input  logic [3:0]  chn_en,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        smpl_vld,
   output logic        a2d_err
);

   localparam logic [2:0]  c_IDLE     = 3'd0;
   localparam logic [2:0]  c_CMD      = 3'd1;
   localparam logic [2:0]  c_GAP      = 3'd2;
   localparam logic [2:0]  c_RD       = 3'd3;
   localparam logic [2:0]  c_UPD      = 3'd4;
   localparam logic [15:0] c_TMO_LAST = TMO_CYCLES - 16'd1;

   logic [2:0]  r_state;
   logic [1:0]  r_ptr;
   logic [1:0]  r_slot;
   logic        r_pend;
   logic [15:0] r_tmo;
   logic        r_spi_wrt;
   logic [15:0] r_spi_cmd;
   logic [11:0] r_lft;
   logic [11:0] r_rght;
   logic [11:0] r_steer;
   logic [11:0] r_batt;
   logic        r_smpl_vld;
   logic        r_a2d_err;

   logic [1:0]  w_p1;
   logic [1:0]  w_p2;
   logic [1:0]  w_p3;
   logic [1:0]  w_sel;
   logic [2:0]  w_chnl;
   logic        w_any;
   logic        w_go;
   logic        w_tmo_hit;
   logic        w_unused;

   // Only the low 12 bits of the read frame carry the conversion result.
   assign w_unused  = ^spi_rd_data[15:12];

   assign w_p1      = r_ptr + 2'd1;
   assign w_p2      = r_ptr + 2'd2;
   assign w_p3      = r_ptr + 2'd3;
   assign w_any     = |chn_en;
   assign w_go      = (r_state == c_IDLE) && w_any && (nxt || r_pend);
   assign w_tmo_hit = (r_tmo == c_TMO_LAST);

   // r_ptr holds the first candidate slot, i.e. the one after the last served.
   always_comb begin
      if (chn_en[r_ptr])
         w_sel = r_ptr;
      else if (chn_en[w_p1])
         w_sel = w_p1;
      else if (chn_en[w_p2])
         w_sel = w_p2;
      else
         w_sel = w_p3;
   end

   always_comb begin
      case (w_sel)
         2'd0:    w_chnl = CH_LFT;
         2'd1:    w_chnl = CH_RGHT;
         2'd2:    w_chnl = CH_STEER;
         default: w_chnl = CH_BATT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_IDLE;
         r_ptr      <= 2'd0;
         r_slot     <= 2'd0;
         r_pend     <= 1'b0;
         r_tmo      <= 16'd0;
         r_spi_wrt  <= 1'b0;
         r_spi_cmd  <= 16'h0000;
         r_lft      <= 12'h000;
         r_rght     <= 12'h000;
         r_steer    <= 12'h000;
         r_batt     <= 12'h000;
         r_smpl_vld <= 1'b0;
         r_a2d_err  <= 1'b0;
      end else begin
         r_spi_wrt  <= 1'b0;
         r_smpl_vld <= 1'b0;
         if (nxt && (r_state != c_IDLE))
            r_pend <= 1'b1;

         case (r_state)
            c_IDLE: begin
               r_pend <= 1'b0;
               if (w_go) begin
                  r_slot    <= w_sel;
                  r_ptr     <= w_sel + 2'd1;
                  r_spi_wrt <= 1'b1;
                  r_spi_cmd <= {2'b00, w_chnl, 11'h000};
                  r_tmo     <= 16'd0;
                  r_state   <= c_CMD;
               end
            end
            c_CMD: begin
               if (spi_done) begin
                  r_state <= c_GAP;
               end else if (w_tmo_hit) begin
                  r_a2d_err <= 1'b1;
                  r_state   <= c_IDLE;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            c_GAP: begin
               r_spi_wrt <= 1'b1;
               r_tmo     <= 16'd0;
               r_state   <= c_RD;
            end
            c_RD: begin
               // Result is captured on spi_done so it is visible the next cycle.
               if (spi_done) begin
                  case (r_slot)
                     2'd0:    r_lft   <= spi_rd_data[11:0];
                     2'd1:    r_rght  <= spi_rd_data[11:0];
                     2'd2:    r_steer <= spi_rd_data[11:0];
                     default: r_batt  <= spi_rd_data[11:0];
                  endcase
                  r_smpl_vld <= 1'b1;
                  r_state    <= c_UPD;
               end else if (w_tmo_hit) begin
                  r_a2d_err <= 1'b1;
                  r_state   <= c_IDLE;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
            end
            c_UPD: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign spi_wrt   = r_spi_wrt;
   assign spi_cmd   = r_spi_cmd;
   assign lft_ld    = r_lft;
   assign rght_ld   = r_rght;
   assign steer_pot = r_steer;
   assign batt      = r_batt;
   assign smpl_vld  = r_smpl_vld;
   assign a2d_err   = r_a2d_err;

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_sched.sv
`default_nettype none
// Bench for a2d_rr_sched: vector table, multi-cycle corner sequences and
// randomized conversions checked against a slot/register reference model.
module tb_a2d_rr_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nxt;
   logic [3:0]  chn_en;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_rd_data;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic [11:0] steer_pot;
   logic [11:0] batt;
   logic        smpl_vld;
   logic        a2d_err;

   a2d_rr_sched #(.TMO_CYCLES(16'd16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .nxt         (nxt),
      .chn_en      (chn_en),
      .spi_wrt     (spi_wrt),
      .spi_cmd     (spi_cmd),
      .spi_done    (spi_done),
      .spi_rd_data (spi_rd_data),
      .lft_ld      (lft_ld),
      .rght_ld     (rght_ld),
      .steer_pot   (steer_pot),
      .batt        (batt),
      .smpl_vld    (smpl_vld),
      .a2d_err     (a2d_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  en;
      logic [11:0] data;
      logic [15:0] cmd;
      logic [11:0] lft;
      logic [11:0] rght;
      logic [11:0] steer;
      logic [11:0] batt;
   } vec_t;

   vec_t        vt[7];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ch_num[4] = '{0, 4, 5, 6};
   int          m_ptr;
   logic [11:0] m_reg[4];
   logic [15:0] c1, c2;
   logic        w_seen, ok;
   int          v_cnt, s;
   logic [3:0]  r_en;
   logic [11:0] d;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic [11:0] l, input logic [11:0] r,
                             input logic [11:0] st, input logic [11:0] b);
      chk({tag, "_lft"},   lft_ld,    l);
      chk({tag, "_rght"},  rght_ld,   r);
      chk({tag, "_steer"}, steer_pot, st);
      chk({tag, "_batt"},  batt,      b);
   endtask

   task automatic do_reset();
      nxt      = 1'b0;
      spi_done = 1'b0;
      rst_n    = 1'b0;
      tick();
      tick();
      rst_n    = 1'b1;
      tick();
   endtask

   task automatic pulse_nxt();
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
   endtask

   task automatic wait_wrt(output logic seen);
      int i;
      i = 0;
      while (!spi_wrt && i < 40) begin
         tick();
         i++;
      end
      seen = spi_wrt;
   endtask

   task automatic respond(input int dly, input logic [11:0] data);
      repeat (dly) tick();
      spi_done    = 1'b1;
      spi_rd_data = {4'($urandom), data};
      tick();
      spi_done    = 1'b0;
   endtask

   // Two-frame SPI exchange; returns at the cycle the result should be visible.
   task automatic conv(input logic [11:0] data, input int d1, input int d2, input bit scr,
                       output logic [15:0] cmd1, output logic [15:0] cmd2);
      logic sn;
      wait_wrt(sn);
      chk("wrt1_seen", sn, 1'b1);
      cmd1 = spi_cmd;
      if (scr) chn_en = 4'($urandom);
      respond(d1, 12'($urandom));
      wait_wrt(sn);
      chk("wrt2_seen", sn, 1'b1);
      cmd2 = spi_cmd;
      respond(d2, data);
   endtask

   function automatic int pick(input int p, input logic [3:0] en);
      for (int k = 0; k < 4; k++)
         if (en[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got time limit exceeded, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; nxt = 1'b0; chn_en = 4'h0; spi_done = 1'b0; spi_rd_data = 16'h0;
      tick();
      chk("rst_wrt", spi_wrt, 0);
      chk("rst_cmd", spi_cmd, 0);
      chk("rst_vld", smpl_vld, 0);
      chk("rst_err", a2d_err, 0);
      check_regs("rst", 12'h0, 12'h0, 12'h0, 12'h0);
      rst_n = 1'b1;

      // Directed vectors: all slots in order, then sparse enable mask
      vt[0] = '{1'b1, 4'hF, 12'hA51, 16'h0000, 12'hA51, 12'h000, 12'h000, 12'h000};
      vt[1] = '{1'b0, 4'hF, 12'h3C0, 16'h2000, 12'hA51, 12'h3C0, 12'h000, 12'h000};
      vt[2] = '{1'b0, 4'hF, 12'h7FF, 16'h2800, 12'hA51, 12'h3C0, 12'h7FF, 12'h000};
      vt[3] = '{1'b0, 4'hF, 12'h123, 16'h3000, 12'hA51, 12'h3C0, 12'h7FF, 12'h123};
      vt[4] = '{1'b1, 4'hA, 12'h111, 16'h2000, 12'h000, 12'h111, 12'h000, 12'h000};
      vt[5] = '{1'b0, 4'hA, 12'h222, 16'h3000, 12'h000, 12'h111, 12'h000, 12'h222};
      vt[6] = '{1'b0, 4'hA, 12'h333, 16'h2000, 12'h000, 12'h333, 12'h000, 12'h222};

      for (int i = 0; i < 7; i++) begin
         if (vt[i].rst) do_reset();
         chn_en = vt[i].en;
         pulse_nxt();
         conv(vt[i].data, 1, 2, 1'b0, c1, c2);
         chk($sformatf("vec%0d_cmd", i),  c1, vt[i].cmd);
         chk($sformatf("vec%0d_cmd2", i), c2, vt[i].cmd);
         chk($sformatf("vec%0d_vld", i),  smpl_vld, 1'b1);
         check_regs($sformatf("vec%0d", i), vt[i].lft, vt[i].rght, vt[i].steer, vt[i].batt);
         tick();
         chk($sformatf("vec%0d_vld_drop", i), smpl_vld, 1'b0);
      end

      // Pending: two extra nxt during CMD yield exactly one extra conversion
      do_reset();
      chn_en = 4'hF;
      pulse_nxt();
      c1 = spi_cmd;
      nxt = 1'b1; tick(); nxt = 1'b0; tick(); nxt = 1'b1; tick(); nxt = 1'b0;
      respond(0, 12'h000);
      wait_wrt(ok);
      chk("pend_wrt2", ok, 1'b1);
      respond(0, 12'h5A5);
      chk("pend_cmd_a", c1, 16'h0000);
      chk("pend_lft", lft_ld, 12'h5A5);
      tick();
      conv(12'h6B6, 1, 1, 1'b0, c1, c2);
      chk("pend_cmd_b", c1, 16'h2000);
      chk("pend_rght", rght_ld, 12'h6B6);
      w_seen = 1'b0;
      repeat (12) begin tick(); w_seen |= spi_wrt; end
      chk("pend_no_third", w_seen, 1'b0);

      // Timeout: no spi_done, err at 16 cycles after spi_wrt
      do_reset();
      chn_en = 4'hF;
      pulse_nxt();
      chk("tmo_wrt", spi_wrt, 1'b1);
      chk("tmo_cmd", spi_cmd, 16'h0000);
      v_cnt = 0;
      repeat (15) begin tick(); if (smpl_vld) v_cnt++; end
      chk("tmo_err_early", a2d_err, 1'b0);
      tick();
      if (smpl_vld) v_cnt++;
      chk("tmo_err_set", a2d_err, 1'b1);
      chk("tmo_no_vld", v_cnt, 0);
      w_seen = 1'b0;
      repeat (6) begin tick(); w_seen |= spi_wrt; end
      chk("tmo_idle", w_seen, 1'b0);
      pulse_nxt();
      conv(12'h9C3, 0, 0, 1'b0, c1, c2);
      chk("tmo_next_cmd", c1, 16'h2000);
      check_regs("tmo_next", 12'h000, 12'h9C3, 12'h000, 12'h000);
      chk("tmo_err_sticky", a2d_err, 1'b1);
      tick();

      // Asynchronous reset during RD discards the result and rewinds the pointer
      do_reset();
      chn_en = 4'hF;
      pulse_nxt();
      conv(12'h0AA, 0, 0, 1'b0, c1, c2);
      chk("arst_pre_lft", lft_ld, 12'h0AA);
      tick();
      pulse_nxt();
      respond(0, 12'h000);
      wait_wrt(ok);
      chk("arst_in_rd", ok, 1'b1);
      spi_rd_data = 16'h0FFF;
      #1 rst_n = 1'b0;
      #1;
      chk("arst_async_wrt", spi_wrt, 1'b0);
      check_regs("arst_async", 12'h0, 12'h0, 12'h0, 12'h0);
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      rst_n = 1'b1;
      tick();
      check_regs("arst_post", 12'h0, 12'h0, 12'h0, 12'h0);
      chk("arst_vld", smpl_vld, 1'b0);
      chk("arst_cmd", spi_cmd, 16'h0000);
      pulse_nxt();
      conv(12'h321, 0, 1, 1'b0, c1, c2);
      chk("arst_first_cmd", c1, 16'h0000);
      chk("arst_first_lft", lft_ld, 12'h321);
      tick();

      // chn_en == 0: nxt ignored and no pending left behind
      do_reset();
      chn_en = 4'h0;
      pulse_nxt();
      w_seen = spi_wrt;
      repeat (8) begin tick(); w_seen |= spi_wrt; end
      chk("dis_no_wrt", w_seen, 1'b0);
      chn_en = 4'h1;
      w_seen = 1'b0;
      repeat (6) begin tick(); w_seen |= spi_wrt; end
      chk("dis_no_pend", w_seen, 1'b0);
      pulse_nxt();
      conv(12'hBEE, 2, 0, 1'b0, c1, c2);
      chk("dis_cmd", c1, 16'h0000);
      chk("dis_lft", lft_ld, 12'hBEE);
      tick();

      // Randomized conversions against the reference model
      do_reset();
      m_ptr = 0;
      for (int k = 0; k < 4; k++) m_reg[k] = 12'h000;
      for (int it = 0; it < 40; it++) begin
         r_en = 4'($urandom);
         if (it % 8 == 3) r_en = 4'h0;
         chn_en = r_en;
         d = 12'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            spi_done = 1'b1;
            spi_rd_data = 16'($urandom);
            tick();
            spi_done = 1'b0;
            chk("rnd_stray_done", {spi_wrt, smpl_vld}, 2'b00);
         end
         s = pick(m_ptr, r_en);
         pulse_nxt();
         if (s < 0) begin
            w_seen = spi_wrt;
            repeat (5) begin tick(); w_seen |= spi_wrt; end
            chk("rnd_idle_wrt", w_seen, 1'b0);
         end else begin
            conv(d, $urandom_range(0, 5), $urandom_range(0, 5), 1'b1, c1, c2);
            m_reg[s] = d;
            m_ptr = (s + 1) % 4;
            chk("rnd_cmd", c1, 32'(ch_num[s] << 11));
            chk("rnd_cmd2", c2, 32'(ch_num[s] << 11));
            chk("rnd_vld", smpl_vld, 1'b1);
            check_regs("rnd", m_reg[0], m_reg[1], m_reg[2], m_reg[3]);
            tick();
         end
      end
      chk("rnd_err", a2d_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
